// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: shares the system-bus master port between CPU, DMAC and other AHB masters.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority (lowest index wins).
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = 3
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;
  localparam logic [1:0] RS_RETRY  = 2'b10;
  localparam logic [1:0] RS_SPLIT  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_BURST, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   grant_idx_q, grant_idx_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic            retry_first_q, retry_first_d;
  logic [MW-1:0]   hmaster_q, hmaster_d;
  logic            hmastlock_q, hmastlock_d;

  logic            resp_rs;
  logic            retry_2nd;
  logic            arb_pt;
  logic            do_arb;
  logic            win_vld;
  logic            win_lock;
  logic [MW-1:0]   win_idx;
  logic            owner_lock;

  // Remaining-beat count loaded on the first address of a fixed-length burst.
  function automatic logic [3:0] burst_load(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_load = 4'd3;
      3'b100, 3'b101: burst_load = 4'd7;
      3'b110, 3'b111: burst_load = 4'd15;
      default:        burst_load = 4'd0;
    endcase
  endfunction

  // RETRY/SPLIT is a two-cycle response: first cycle HREADY low, second HREADY high.
  always_comb begin
    resp_rs       = (HRESP == RS_RETRY) || (HRESP == RS_SPLIT);
    retry_2nd     = resp_rs && HREADY && retry_first_q;
    retry_first_d = resp_rs && !HREADY;
    arb_pt = HREADY && ((HTRANS == TR_IDLE) ||
                        ((HTRANS == TR_SEQ) && (beat_cnt_q == 4'd1)) ||
                        (((HBURST == BU_SINGLE) || (HBURST == BU_INCR)) &&
                         ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ))) ||
                        retry_2nd);
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (retry_2nd) begin
      beat_cnt_d = 4'd0;
    end else if (HREADY && (HTRANS == TR_NONSEQ)) begin
      beat_cnt_d = burst_load(HBURST);
    end else if (HREADY && (HTRANS == TR_SEQ) && (beat_cnt_q != 4'd0)) begin
      beat_cnt_d = beat_cnt_q - 4'd1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [MW-1:0] rr_ptr_q, rr_ptr_d;

  // Search starts one past the last master that actually took the bus.
  always_comb begin
    int tgt;
    tgt      = 0;
    win_vld  = 1'b0;
    win_lock = 1'b0;
    win_idx  = MW'(DEFAULT_MASTER);
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      tgt = (int'(rr_ptr_q) + k) % NUM_MASTERS;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!win_vld && HBUSREQ[i] && (i == tgt)) begin
          win_vld  = 1'b1;
          win_lock = HLOCK[i];
          win_idx  = MW'(i);
        end
      end
    end
    rr_ptr_d = (do_arb && win_vld) ? win_idx : rr_ptr_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) rr_ptr_q <= MW'(NUM_MASTERS - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win_vld  = 1'b0;
    win_lock = 1'b0;
    win_idx  = MW'(DEFAULT_MASTER);
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (HBUSREQ[i]) begin
        win_vld  = 1'b1;
        win_lock = HLOCK[i];
        win_idx  = MW'(i);
      end
    end
  end
`endif

  always_comb begin
    owner_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_q == MW'(i)) owner_lock = HLOCK[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    do_arb      = 1'b0;
    case (state_q)
      ST_IDLE:           if (|HBUSREQ) state_d = ST_ARB;
      ST_ARB, ST_BURST:  do_arb = arb_pt;
      ST_LOCKED:         do_arb = arb_pt && !owner_lock;
      default:           state_d = ST_IDLE;
    endcase
    if (do_arb) begin
      if (win_vld) begin
        grant_idx_d = win_idx;
        state_d     = win_lock ? ST_LOCKED : ST_BURST;
      end else begin
        grant_idx_d = MW'(DEFAULT_MASTER);
        state_d     = ST_IDLE;
      end
    end
  end

  // Owner/lock follow the grant by one accepted address phase.
  always_comb begin
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (HREADY) begin
      hmaster_d   = grant_idx_q;
      hmastlock_d = (state_q == ST_LOCKED);
    end
  end

  always_comb begin
    HGRANT = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      HGRANT[i] = (grant_idx_q == MW'(i));
    end
  end

  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= MW'(DEFAULT_MASTER);
      beat_cnt_q    <= 4'd0;
      retry_first_q <= 1'b0;
      hmaster_q     <= MW'(DEFAULT_MASTER);
      hmastlock_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      beat_cnt_q    <= beat_cnt_d;
      retry_first_q <= retry_first_d;
      hmaster_q     <= hmaster_d;
      hmastlock_q   <= hmastlock_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, priority, bursts, lock, RETRY, wait states, async reset.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [2:0] HBUSREQ, HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [2:0] HGRANT;
  logic [2:0] HMASTER;
  logic       HMASTLOCK;

  int checks   = 0;
  int failures = 0;

  ahb_bus_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .MW(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (!HRESET) begin
      checks++;
      assert ($onehot(HGRANT)) else begin
        failures++;
        $error("FAIL onehot observed=%b expected=one-hot", HGRANT);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    HTRANS = tr;
    HBURST = bu;
    HREADY = rdy;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [31:0] exp_b3;
    HRESET = 1'b1; HBUSREQ = 3'b000; HLOCK = 3'b000; HRESP = 2'b00;
    tick(IDLE, SINGLE, 1'b1);
    tick(IDLE, SINGLE, 1'b1);
    chk("rst_hgrant", 32'(HGRANT), 32'h1);
    chk("rst_hmaster", 32'(HMASTER), 32'h0);
    chk("rst_hmastlock", 32'(HMASTLOCK), 32'h0);
    chk("rst_beat_cnt", 32'(dut.beat_cnt_q), 32'h0);
    HRESET = 1'b0;

    // CPU and DMAC both requesting on SINGLE transfers
    HBUSREQ = 3'b011;
    tick(IDLE, SINGLE, 1'b1);
    chk("prio_idle_to_arb", 32'(HGRANT), 32'h1);
    tick(IDLE, SINGLE, 1'b1);
    chk("prio_arb1", 32'(HGRANT), 32'h1);
`ifdef ARB_ROUND_ROBIN_EN
    exp_b3 = 32'h2;
`else
    exp_b3 = 32'h1;
`endif
    tick(NONSEQ, SINGLE, 1'b1);
    chk("prio_arb2", 32'(HGRANT), exp_b3);
    tick(NONSEQ, SINGLE, 1'b1);
    chk("prio_arb3", 32'(HGRANT), 32'h1);

    // DMAC INCR4, CPU requests on beat 2
    HBUSREQ = 3'b010;
    tick(IDLE, SINGLE, 1'b1);
    chk("incr4_grant_dmac", 32'(HGRANT), 32'h2);
    tick(NONSEQ, INCR4, 1'b1);
    chk("incr4_hmaster", 32'(HMASTER), 32'h1);
    chk("incr4_load", 32'(dut.beat_cnt_q), 32'h3);
    HBUSREQ = 3'b011;
    tick(SEQ, INCR4, 1'b1);
    chk("incr4_beat2", 32'(HGRANT), 32'h2);
    tick(SEQ, INCR4, 1'b1);
    chk("incr4_beat3", 32'(HGRANT), 32'h2);
    tick(SEQ, INCR4, 1'b1);
    chk("incr4_regrant_cpu", 32'(HGRANT), 32'h1);
    chk("incr4_hmaster_hold", 32'(HMASTER), 32'h1);
    chk("incr4_cnt_done", 32'(dut.beat_cnt_q), 32'h0);
    HBUSREQ = 3'b001;
    tick(IDLE, SINGLE, 1'b1);
    chk("incr4_hmaster_cpu", 32'(HMASTER), 32'h0);

    // Locked DMAC: two INCR8 bursts with CPU requesting
    HBUSREQ = 3'b010; HLOCK = 3'b010;
    tick(IDLE, SINGLE, 1'b1);
    chk("lock_grant", 32'(HGRANT), 32'h2);
    HBUSREQ = 3'b011;
    for (int b = 0; b < 2; b++) begin
      tick(NONSEQ, INCR8, 1'b1);
      chk("lock_nonseq_grant", 32'(HGRANT), 32'h2);
      chk("lock_hmastlock", 32'(HMASTLOCK), 32'h1);
      for (int s = 0; s < 7; s++) begin
        tick(SEQ, INCR8, 1'b1);
        chk("lock_seq_grant", 32'(HGRANT), 32'h2);
      end
    end
    chk("lock_hmaster", 32'(HMASTER), 32'h1);
    HLOCK = 3'b000;
    tick(IDLE, SINGLE, 1'b1);
    chk("lock_release", 32'(HGRANT), 32'h1);
    tick(IDLE, SINGLE, 1'b1);
    chk("lock_hmastlock_clr", 32'(HMASTLOCK), 32'h0);
    chk("lock_hmaster_cpu", 32'(HMASTER), 32'h0);

    // ERROR then RETRY inside a DMAC INCR4 burst, CPU requesting
    HBUSREQ = 3'b010;
    tick(IDLE, SINGLE, 1'b1);
    chk("retry_grant_dmac", 32'(HGRANT), 32'h2);
    HBUSREQ = 3'b011;
    tick(NONSEQ, INCR4, 1'b1);
    HRESP = 2'b01;
    tick(SEQ, INCR4, 1'b0);
    tick(SEQ, INCR4, 1'b1);
    chk("error_no_rearb", 32'(HGRANT), 32'h2);
    chk("error_cnt", 32'(dut.beat_cnt_q), 32'h2);
    HRESP = 2'b10;
    tick(SEQ, INCR4, 1'b0);
    chk("retry1_grant", 32'(HGRANT), 32'h2);
    chk("retry1_cnt", 32'(dut.beat_cnt_q), 32'h2);
    tick(SEQ, INCR4, 1'b1);
    chk("retry2_grant_cpu", 32'(HGRANT), 32'h1);
    chk("retry2_cnt_clr", 32'(dut.beat_cnt_q), 32'h0);
    HRESP = 2'b00; HBUSREQ = 3'b001;
    tick(IDLE, SINGLE, 1'b1);
    chk("retry_hmaster_cpu", 32'(HMASTER), 32'h0);

    // Wait states at an arbitration point with a new DMAC request
    HBUSREQ = 3'b010;
    for (int w = 0; w < 5; w++) begin
      tick(IDLE, SINGLE, 1'b0);
      chk("wait_grant_hold", 32'(HGRANT), 32'h1);
      chk("wait_hmaster_hold", 32'(HMASTER), 32'h0);
    end
    tick(IDLE, SINGLE, 1'b1);
    chk("wait_release_grant", 32'(HGRANT), 32'h2);
    chk("wait_release_hmaster", 32'(HMASTER), 32'h0);

    // Async reset in the middle of an INCR16
    tick(NONSEQ, INCR16, 1'b1);
    chk("incr16_hmaster", 32'(HMASTER), 32'h1);
    chk("incr16_load", 32'(dut.beat_cnt_q), 32'hf);
    tick(SEQ, INCR16, 1'b1);
    tick(SEQ, INCR16, 1'b1);
    chk("incr16_cnt", 32'(dut.beat_cnt_q), 32'hd);
    #2;
    HRESET = 1'b1;
    #1;
    chk("arst_hgrant", 32'(HGRANT), 32'h1);
    chk("arst_hmaster", 32'(HMASTER), 32'h0);
    chk("arst_hmastlock", 32'(HMASTLOCK), 32'h0);
    chk("arst_beat_cnt", 32'(dut.beat_cnt_q), 32'h0);
    tick(IDLE, SINGLE, 1'b1);
    HRESET = 1'b0; HBUSREQ = 3'b000;
    tick(IDLE, SINGLE, 1'b1);
    chk("post_rst_default", 32'(HGRANT), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
